// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch-PC driven instruction prefetch FIFO with redirect flush
module instr_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [63:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_rdata,
  input  logic                    imem_err,
  input  logic                    redirect,
  input  logic [63:0]             redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_pc,
  output logic [31:0]             out_instr,
  output logic                    out_err,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [63:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic err_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [63:0] fetch_pc, fetch_pc_n, addr_n;
  logic [CW-1:0] count_n;
  logic drop, halt, drop_n, halt_n, req_n, push, pop, busy;
  assign out_valid = count != '0;
  assign out_pc = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
  assign out_err = err_mem[rd_ptr];
  // next-state: redirect flushes the queue, a pending fetch is dropped rather than abandoned
  always_comb begin
    busy = imem_req & ~imem_ack;
    push = imem_req & imem_ack & ~drop & ~redirect;
    pop = out_valid & out_ready & ~redirect;
    count_n = redirect ? '0 : count + CW'(push) - CW'(pop);
    fetch_pc_n = redirect ? redirect_pc & ~64'd3 : push ? fetch_pc + 64'd4 : fetch_pc;
    drop_n = busy & (drop | redirect);
    halt_n = redirect ? 1'b0 : halt | (push & imem_err);
    req_n = busy | (~halt_n & (count_n < CW'(DEPTH)));
    addr_n = busy ? imem_addr : fetch_pc_n;
  end
  // control state and FIFO pointers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      drop <= 1'b0;
      halt <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      imem_req <= req_n;
      imem_addr <= addr_n;
      fetch_pc <= fetch_pc_n;
      drop <= drop_n;
      halt <= halt_n;
      count <= count_n;
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
    end
  // FIFO storage; cleared on reset so the empty head reads as zero
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        instr_mem[i] <= '0;
        err_mem[i] <= 1'b0;
      end
    end else if (push) begin
      pc_mem[wr_ptr] <= imem_addr;
      instr_mem[wr_ptr] <= imem_rdata;
      err_mem[wr_ptr] <= imem_err;
    end
endmodule
